// File: rtl/rb_pkg.sv
// rb_pkg: shared frame geometry and receiver state encoding for the S1/S2/RB2 chain
package rb_pkg;
  localparam int RB_ADDR_W = 3;
  localparam int RB_DATA_W = 18;
  localparam int RB_NUM_WORDS = 8;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, WAIT_HI, DONE} state_t;
endpackage

// File: rtl/serial_shift_rx.sv
// serial_shift_rx: MSB-first left shift register capturing one serial field
module serial_shift_rx #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         d,
  output logic [W-1:0] q
);
  // shift the new bit in at the LSB so the first bit received ends up at the MSB
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (shift_en) q <= W'({q, d});
endmodule

// File: rtl/s2_serial_receiver.sv
// s2_serial_receiver: deserialises framed sen/sd traffic into RB2 register writes
module s2_serial_receiver
  import rb_pkg::*;
#(
  parameter int ADDR_W = RB_ADDR_W,
  parameter int DATA_W = RB_DATA_W,
  parameter int NUM_WORDS = RB_NUM_WORDS
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              S2_done
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int FW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_WORDS - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [FW-1:0] r_frames;
  logic [ADDR_W-1:0] r_a, w_addr;
  logic [DATA_W-1:0] r_d, w_data;
  logic w_addr_en, w_data_en, w_write;
  serial_shift_rx #(.W(ADDR_W)) u_addr (.clk(clk), .rst(rst), .shift_en(w_addr_en), .d(sd), .q(w_addr));
  serial_shift_rx #(.W(DATA_W)) u_data (.clk(clk), .rst(rst), .shift_en(w_data_en), .d(sd), .q(w_data));
  // state, bit counter, frame counter and the held copy of the last write
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_frames <= '0;
      r_a <= '0;
      r_d <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      if (w_write) begin
        r_frames <= r_frames + 1'b1;
        r_a <= w_addr;
        r_d <= w_data;
      end
    end
  // frame sequencing: a high sen mid-frame aborts, bits past the frame wait for sen high
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE:
        if (!sen) begin
          w_next = (ADDR_W == 1) ? DATA : ADDR;
          w_cnt_next = (ADDR_W == 1) ? '0 : CW'(1);
        end
      ADDR:
        if (sen) begin
          w_next = IDLE;
          w_cnt_next = '0;
        end else begin
          w_next = (r_cnt == ADDR_LAST) ? DATA : ADDR;
          w_cnt_next = (r_cnt == ADDR_LAST) ? '0 : r_cnt + 1'b1;
        end
      DATA:
        if (sen) begin
          w_next = IDLE;
          w_cnt_next = '0;
        end else begin
          w_next = (r_cnt == DATA_LAST) ? WRITE : DATA;
          w_cnt_next = (r_cnt == DATA_LAST) ? '0 : r_cnt + 1'b1;
        end
      WRITE:   w_next = (r_frames == FRAME_LAST) ? DONE : WAIT_HI;
      WAIT_HI: w_next = sen ? IDLE : WAIT_HI;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // outputs: the write cycle shows the live shift registers, otherwise the held copy
  always_comb begin
    w_write = (r_state == WRITE);
    w_addr_en = !sen && (r_state == IDLE || r_state == ADDR);
    w_data_en = !sen && (r_state == DATA);
    RB2_RW = !w_write;
    RB2_A = w_write ? w_addr : r_a;
    RB2_D = w_write ? w_data : r_d;
    S2_done = (r_state == DONE);
  end
endmodule

// File: tb/tb_s2_serial_receiver.sv
// tb_s2_serial_receiver: directed frames against s2_serial_receiver with hand-derived expectations
module tb_s2_serial_receiver;
  logic clk = 0, rst = 1, sen = 1, sd = 0;
  logic rw, done;
  logic [2:0] a;
  logic [17:0] d;
  int n_run = 0, n_fail = 0;
  int wr_cnt = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [2:0] last_a;
  logic [17:0] last_d;
  logic done_q = 0;
  s2_serial_receiver dut (.clk(clk), .rst(rst), .sen(sen), .sd(sd), .RB2_RW(rw), .RB2_A(a), .RB2_D(d), .S2_done(done));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (!rw) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      last_a = a;
      last_d = d;
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen = 1;
      sd = 0;
    end
  endtask
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sen = 0;
      sd = bits[i];
    end
    idle(3);
  endtask
  task automatic frame(input logic [2:0] fa, input logic [17:0] fd);
    send_bits({11'b0, fa, fd}, 21);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    sen = 1;
    idle(2);
    rst = 0;
    idle(1);
  endtask
  function automatic logic [17:0] ramp_word(input int ad);
    logic [17:0] w;
    logic [7:0] b;
    for (int i = 0; i < 18; i++) begin
      b = 8'(i);
      w[17 - i] = b[7 - ad];
    end
    return w;
  endfunction
  initial begin
    int w0;
    do_reset();
    check("reset_rw", rw, 1);
    check("reset_a", a, 0);
    check("reset_d", d, 0);
    check("reset_done", done, 0);
    // 1: single good frame
    w0 = wr_cnt;
    frame(3'b101, 18'h2A5A5);
    check("t1_writes", wr_cnt - w0, 1);
    check("t1_a", last_a, 5);
    check("t1_d", last_d, 18'h2A5A5);
    check("t1_done", done, 0);
    check("t1_rw_idle", rw, 1);
    check("t1_a_hold", a, 5);
    check("t1_d_hold", d, 18'h2A5A5);
    // 2: full run of a ramp through an S1-style transposition
    do_reset();
    w0 = wr_cnt;
    for (int k = 0; k < 8; k++) begin
      frame(3'(k), ramp_word(k));
      check($sformatf("t2_a%0d", k), last_a, k);
      check($sformatf("t2_d%0d", k), last_d, ramp_word(k));
    end
    check("t2_d7_hand", last_d, 18'h15555);
    check("t2_writes", wr_cnt - w0, 8);
    check("t2_done", done, 1);
    check("t2_done_lat", done_cyc - last_wr_cyc, 1);
    idle(5);
    check("t2_done_hold", done, 1);
    // 3: short frame discarded, frame count unaffected
    do_reset();
    w0 = wr_cnt;
    send_bits(32'h1A5B, 13);
    check("t3_short_nowr", wr_cnt - w0, 0);
    frame(3'd2, 18'h1F00F);
    check("t3_writes", wr_cnt - w0, 1);
    check("t3_a", last_a, 2);
    check("t3_d", last_d, 18'h1F00F);
    for (int k = 0; k < 6; k++) frame(3'(k), 18'(k));
    check("t3_done_at7", done, 0);
    frame(3'd7, 18'h00077);
    check("t3_done_at8", done, 1);
    // 4: overlong frame, trailing bits ignored
    do_reset();
    w0 = wr_cnt;
    send_bits({7'b0, 3'b110, 18'h3C3C3, 4'b1011}, 25);
    check("t4_writes", wr_cnt - w0, 1);
    check("t4_a", last_a, 6);
    check("t4_d", last_d, 18'h3C3C3);
    frame(3'd1, 18'h0000F);
    check("t4_next_a", last_a, 1);
    check("t4_next_d", last_d, 18'h0000F);
    // 5: reset in the middle of the data field
    do_reset();
    frame(3'd7, 18'h3FFFF);
    w0 = wr_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sen = 0;
      sd = 1;
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t5_rw", rw, 1);
    check("t5_a", a, 0);
    check("t5_d", d, 0);
    check("t5_done", done, 0);
    check("t5_nowr", wr_cnt - w0, 0);
    rst = 0;
    idle(2);
    frame(3'd1, 18'h12345);
    check("t5_writes", wr_cnt - w0, 1);
    check("t5_new_a", last_a, 1);
    check("t5_new_d", last_d, 18'h12345);
    // 6: duplicate address frames still count, frames after DONE are ignored
    do_reset();
    w0 = wr_cnt;
    for (int k = 0; k < 8; k++) frame(3'd3, {3'(k), 15'h1234});
    check("t6_writes", wr_cnt - w0, 8);
    check("t6_d", last_d, 18'h39234);
    check("t6_done", done, 1);
    frame(3'd5, 18'h00001);
    frame(3'd6, 18'h00002);
    check("t6_post_writes", wr_cnt - w0, 8);
    check("t6_a_hold", a, 3);
    check("t6_d_hold", d, 18'h39234);
    check("t6_done_hold", done, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
